// File: rtl/ecall_io_responder_if.sv
// Board-side ecall handshake bundle between the core/board pins and the responder.
// The master side drives the request and raw board inputs. The slave side returns the release strobe and the captured word.
interface ecall_io_responder_if #(
    parameter int DATA_W = 16
);
    logic              ecall_req;
    logic              ecall_is_input;
    logic [DATA_W-1:0] switches;
    logic              confirm_btn;
    logic              continue_pulse;
    logic [31:0]       io_data;
    logic              io_valid;
    logic              wait_led;
    logic              busy;

    modport master (
        output ecall_req, ecall_is_input, switches, confirm_btn,
        input  continue_pulse, io_data, io_valid, wait_led, busy
    );

    modport slave (
        input  ecall_req, ecall_is_input, switches, confirm_btn,
        output continue_pulse, io_data, io_valid, wait_led, busy
    );
endinterface

// File: rtl/ecall_io_responder.sv
// Debounces the confirm button and samples the switches while the core stalls in an ecall.
// It then releases the core with a one-cycle continue pulse and holds the captured switch word.
module ecall_io_responder #(
    parameter int DEBOUNCE_CYCLES = 230000,
    parameter int DATA_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ecall_io_responder_if.slave  bus
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RELEASE,
        ARMED,
        ACK,
        WAIT_DROP
    } state_t;

    state_t             state_q, state_d;
    logic               btn_sync_p0, btn_sync_p1;
    logic [DATA_W-1:0]  sw_sync_p0, sw_sync_p1;
    logic [CNT_W-1:0]   db_cnt;
    logic               btn_db, btn_db_prev;
    logic               press;
    logic               capture;
    logic [31:0]        io_data_q;
    logic               io_valid_q;

    // Stage p0/p1: two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
            sw_sync_p0  <= '0;
            sw_sync_p1  <= '0;
        end else begin
            btn_sync_p0 <= bus.confirm_btn;
            btn_sync_p1 <= btn_sync_p0;
            sw_sync_p0  <= bus.switches;
            sw_sync_p1  <= sw_sync_p0;
        end
    end

    // A new level must persist for DEBOUNCE_CYCLES consecutive cycles before btn_db follows it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt      <= '0;
            btn_db      <= 1'b0;
            btn_db_prev <= 1'b0;
        end else begin
            btn_db_prev <= btn_db;
            if (btn_sync_p1 != btn_db) begin
                if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db <= ~btn_db;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = btn_db & ~btn_db_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A dropped request always takes priority over a coincident press
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ecall_req) begin
                    state_d = btn_db ? WAIT_RELEASE : ARMED;
                end
            end
            WAIT_RELEASE: begin
                if (!bus.ecall_req) begin
                    state_d = IDLE;
                end else if (!btn_db) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!bus.ecall_req) begin
                    state_d = IDLE;
                end else if (press) begin
                    state_d = ACK;
                    capture = 1'b1;
                end
            end
            ACK: begin
                state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!bus.ecall_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_data_q  <= '0;
            io_valid_q <= 1'b0;
        end else begin
            if (capture && bus.ecall_is_input) begin
                io_data_q  <= 32'(sw_sync_p1);
                io_valid_q <= 1'b1;
            end else if (state_d == IDLE) begin
                io_valid_q <= 1'b0;
            end
        end
    end

    assign bus.continue_pulse = (state_q == ACK);
    assign bus.io_data        = io_data_q;
    assign bus.io_valid       = io_valid_q;
    assign bus.wait_led       = (state_q == ARMED) && bus.ecall_is_input;
    assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_ecall_io_responder.sv
// Scoreboard bench for ecall_io_responder: expected releases are queued at stimulus time.
// A monitor checks each continue pulse against the queue head.
module tb_ecall_io_responder;
    localparam int DC = 4;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc = 0;
    int          tests = 0;
    int          failed = 0;
    logic [31:0] model_data = '0;
    exp_t        sb_q[$];

    ecall_io_responder_if #(.DATA_W(16)) bus ();

    ecall_io_responder #(.DEBOUNCE_CYCLES(DC), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every release strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset && bus.continue_pulse === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_io_data", bus.io_data, e.data);
                chk("pulse_io_valid", {31'd0, bus.io_valid}, {31'd0, e.valid});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A clean press accepted while ARMED releases the core 2 sync + DC + 1 cycles after the raw edge
    task automatic press_exp(input int hold, input logic iin, input logic [15:0] sw);
        exp_t e;
        if (iin) model_data = {16'h0, sw};
        e.cyc   = cyc + 3 + DC;
        e.data  = model_data;
        e.valid = iin;
        sb_q.push_back(e);
        bus.confirm_btn = 1'b1;
        tick(hold);
        bus.confirm_btn = 1'b0;
    endtask

    task automatic bounce(input int cycles);
        int n = 0;
        while (n < cycles) begin
            int h = $urandom_range(1, DC - 1);
            int l = $urandom_range(1, 3);
            bus.confirm_btn = 1'b1;
            tick(h);
            bus.confirm_btn = 1'b0;
            tick(l);
            n += h + l;
        end
    endtask

    task automatic handshake(input logic iin, input logic [15:0] sw, input int hold,
                             input logic do_bounce, input logic second_press);
        bus.ecall_is_input = iin;
        bus.switches       = sw;
        bus.ecall_req      = 1'b1;
        tick(4);
        @(negedge clk);
        chk("armed_busy", {31'd0, bus.busy}, 32'd1);
        chk("armed_wait_led", {31'd0, bus.wait_led}, {31'd0, iin});
        if (do_bounce) begin
            tick(1);
            bounce(20);
            tick(DC + 4);
            @(negedge clk);
            chk("bounce_still_armed", {31'd0, bus.wait_led}, {31'd0, iin});
            chk("bounce_busy", {31'd0, bus.busy}, 32'd1);
        end
        tick(1);
        press_exp(hold, iin, sw);
        @(negedge clk);
        chk("post_ack_io_valid", {31'd0, bus.io_valid}, {31'd0, iin});
        chk("post_ack_wait_led", {31'd0, bus.wait_led}, 32'd0);
        chk("post_ack_io_data", bus.io_data, model_data);
        tick(DC + 4);
        if (second_press) begin
            bus.switches    = ~sw;
            bus.confirm_btn = 1'b1;
            tick(hold);
            bus.confirm_btn = 1'b0;
            tick(DC + 4);
            @(negedge clk);
            chk("wait_drop_busy", {31'd0, bus.busy}, 32'd1);
            chk("wait_drop_io_data", bus.io_data, model_data);
            tick(1);
        end
        bus.ecall_req = 1'b0;
        tick(1);
        @(negedge clk);
        chk("drop_io_valid", {31'd0, bus.io_valid}, 32'd0);
        chk("drop_busy", {31'd0, bus.busy}, 32'd0);
        chk("drop_io_data", bus.io_data, model_data);
        tick(2);
    endtask

    initial begin
        int unsigned k;
        bus.ecall_req      = 1'b1;
        bus.ecall_is_input = 1'b1;
        bus.switches       = 16'hFFFF;
        bus.confirm_btn    = 1'b0;
        tick(3);
        @(negedge clk);
        chk("reset_continue_pulse", {31'd0, bus.continue_pulse}, 32'd0);
        chk("reset_io_data", bus.io_data, 32'd0);
        chk("reset_io_valid", {31'd0, bus.io_valid}, 32'd0);
        chk("reset_wait_led", {31'd0, bus.wait_led}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        bus.ecall_req = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);

        // display/exit request: pulse only, io_data untouched
        handshake(1'b0, 16'h1234, 10, 1'b0, 1'b0);
        // read request, plus a held re-press in WAIT_DROP that must be ignored
        handshake(1'b1, 16'h00A5, 10, 1'b0, 1'b1);
        // bounce first, then a real press
        handshake(1'b1, 16'h5A3C, 10, 1'b1, 1'b0);

        // button already held as the request rises
        bus.confirm_btn = 1'b1;
        tick(DC + 6);
        bus.ecall_is_input = 1'b1;
        bus.switches       = 16'hBEEF;
        bus.ecall_req      = 1'b1;
        tick(5);
        @(negedge clk);
        chk("held_busy", {31'd0, bus.busy}, 32'd1);
        chk("held_wait_led", {31'd0, bus.wait_led}, 32'd0);
        tick(1);
        bus.confirm_btn = 1'b0;
        tick(DC + 5);
        @(negedge clk);
        chk("released_wait_led", {31'd0, bus.wait_led}, 32'd1);
        tick(1);
        press_exp(10, 1'b1, 16'hBEEF);
        tick(DC + 4);
        bus.ecall_req = 1'b0;
        tick(3);

        // request drops in the same cycle as the press event
        bus.switches  = 16'h0F0F;
        bus.ecall_req = 1'b1;
        tick(4);
        bus.confirm_btn = 1'b1;
        tick(DC + 2);
        bus.ecall_req = 1'b0;
        tick(1);
        @(negedge clk);
        chk("drop_at_press_busy", {31'd0, bus.busy}, 32'd0);
        chk("drop_at_press_io_data", bus.io_data, model_data);
        tick(1);
        bus.confirm_btn = 1'b0;
        tick(DC + 6);

        // reset asserted in ACK
        bus.ecall_is_input = 1'b1;
        bus.switches       = 16'hC0DE;
        bus.ecall_req      = 1'b1;
        tick(4);
        k = cyc;
        bus.confirm_btn = 1'b1;
        tick(DC + 3);
        reset = 1'b0;
        model_data = '0;
        @(negedge clk);
        chk("reset_in_ack_cycle", cyc, k + DC + 3);
        chk("reset_in_ack_pulse", {31'd0, bus.continue_pulse}, 32'd0);
        chk("reset_in_ack_io_data", bus.io_data, 32'd0);
        bus.ecall_req   = 1'b0;
        bus.confirm_btn = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(DC + 6);
        @(negedge clk);
        chk("after_reset_busy", {31'd0, bus.busy}, 32'd0);
        tick(1);

        for (int i = 0; i < 10; i++) begin
            handshake(1'($urandom_range(0, 1)), 16'($urandom),
                      $urandom_range(DC + 4, DC + 10),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        tick(5);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
